uart_tx: RTL and testbench

- 8N1 UART transmitter; the transmit-side counterpart of the team's uart_rx block.
- Same bit timing as uart_rx: 50 MHz clock, 115200 baud, 434 clocks per bit.
- Serialises one byte per request on a single line, LSB first.
- Reports busy/done so a host FSM can stream messages back-to-back with no idle gap between frames.

---
 rtl/uart_tx_if.sv | 19 +
 rtl/uart_tx.sv | 142 ++++++++++++++
 tb/tb_uart_tx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-stream handshake between a host and the uart_tx serialiser.
// The host owns tx_data/tx_start; the transmitter owns the line and status flags.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_data, tx_start,
        input  tx, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_start,
        output tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 (optionally 8E1/8O1) UART transmitter, LSB first, matching uart_rx bit timing.
// A request seen on the edge that ends the stop bit starts the next frame with no idle gap.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_MODE  = 0
) (
    input  logic     clk_50M,
    input  logic     reset,
    uart_tx_if.slave bus
);

    localparam int             CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_MAX    = CW'(CLKS_PER_BIT - 1);
    localparam logic           ODD_PARITY = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift_reg, shift_reg_n;
    logic          parity_q, parity_n;
    logic          tx_q, tx_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          bit_end;
    logic          accept;

    assign bit_end = (clk_cnt == CNT_MAX);

    // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        clk_cnt_n   = clk_cnt + 1'b1;
        bit_idx_n   = bit_idx;
        shift_reg_n = shift_reg;
        parity_n    = parity_q;
        tx_n        = tx_q;
        busy_n      = busy_q;
        done_n      = 1'b0;
        accept      = 1'b0;

        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                accept    = bus.tx_start;
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = DATA;
                    tx_n      = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        if (PARITY_MODE != 0) begin
                            state_n = PARITY;
                            tx_n    = parity_q;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_idx_n   = bit_idx + 3'd1;
                        shift_reg_n = {1'b0, shift_reg[7:1]};
                        tx_n        = shift_reg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = STOP;
                    tx_n      = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = IDLE;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                    accept    = bus.tx_start;
                end
            end
            default: begin
                state_n   = IDLE;
                clk_cnt_n = '0;
                tx_n      = 1'b1;
                busy_n    = 1'b0;
            end
        endcase

        // Start bit goes out on the accept edge itself; parity is fixed from the latched byte.
        if (accept) begin
            state_n     = START;
            clk_cnt_n   = '0;
            bit_idx_n   = '0;
            shift_reg_n = bus.tx_data;
            parity_n    = (^bus.tx_data) ^ ODD_PARITY;
            tx_n        = 1'b0;
            busy_n      = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            clk_cnt   <= clk_cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_reg_n;
            parity_q  <= parity_n;
            tx_q      <= tx_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, parity, back-to-back streaming,
// ignored mid-frame requests, asynchronous reset and a bench-side receiver.
module tb_uart_tx;

    localparam int CPB   = 434;
    localparam int FRAME = 10 * CPB;

    logic clk;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    int bad[22];
    int busy_bad;
    int done_cnt;
    int e_bad, o_bad, e_done, o_done;

    logic [9:0]  exp_a, exp_b;
    logic [10:0] exp_even, exp_odd;
    logic [7:0]  sent[10];
    logic [7:0]  rx[10];

    uart_tx_if if0();
    uart_tx_if if_even();
    uart_tx_if if_odd();

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_MODE(0)) dut (
        .clk_50M (clk),
        .reset   (reset),
        .bus     (if0)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_MODE(1)) dut_even (
        .clk_50M (clk),
        .reset   (reset),
        .bus     (if_even)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_MODE(2)) dut_odd (
        .clk_50M (clk),
        .reset   (reset),
        .bus     (if_odd)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clear_counts();
        foreach (bad[i]) bad[i] = 0;
        busy_bad = 0;
        done_cnt = 0;
    endtask

    initial begin
        reset           = 1'b1;
        if0.tx_start     = 1'b0;
        if0.tx_data      = 8'h00;
        if_even.tx_start = 1'b0;
        if_even.tx_data  = 8'h00;
        if_odd.tx_start  = 1'b0;
        if_odd.tx_data   = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", if0.tx, 1'b1);
        check("rst_busy", if0.tx_busy, 1'b0);
        check("rst_done", if0.tx_done, 1'b0);
        check("rst_even_tx", if_even.tx, 1'b1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_tx", if0.tx, 1'b1);
        check("idle_busy", if0.tx_busy, 1'b0);

        // Test 1: 0x41 single pulse; 0x07 with even and odd parity in parallel
        exp_a    = {1'b1, 8'h41, 1'b0};
        exp_even = {1'b1, 1'b1, 8'h07, 1'b0};
        exp_odd  = {1'b1, 1'b0, 8'h07, 1'b0};
        clear_counts();
        e_bad = 0; o_bad = 0; e_done = 0; o_done = 0;
        if0.tx_data      = 8'h41;
        if0.tx_start     = 1'b1;
        if_even.tx_data  = 8'h07;
        if_even.tx_start = 1'b1;
        if_odd.tx_data   = 8'h07;
        if_odd.tx_start  = 1'b1;
        for (int c = 0; c <= 11 * CPB + 1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if0.tx_start     = 1'b0;
                if_even.tx_start = 1'b0;
                if_odd.tx_start  = 1'b0;
            end
            if (c < FRAME) begin
                if (if0.tx !== exp_a[c / CPB]) bad[c / CPB]++;
                if (if0.tx_busy !== 1'b1) busy_bad++;
            end
            if (c < 11 * CPB) begin
                if (if_even.tx !== exp_even[c / CPB] || if_even.tx_busy !== 1'b1) e_bad++;
                if (if_odd.tx !== exp_odd[c / CPB] || if_odd.tx_busy !== 1'b1) o_bad++;
            end
            if (c == FRAME) begin
                check("t1_done_at_4340", if0.tx_done, 1'b1);
                check("t1_busy_end", if0.tx_busy, 1'b0);
            end
            if (c == FRAME + 1) check("t1_done_width", if0.tx_done, 1'b0);
            if (c == 11 * CPB) begin
                check("t1_even_done_at_4774", if_even.tx_done, 1'b1);
                check("t1_odd_done_at_4774", if_odd.tx_done, 1'b1);
                check("t1_even_busy_end", if_even.tx_busy, 1'b0);
            end
            if (if0.tx_done) done_cnt++;
            if (if_even.tx_done) e_done++;
            if (if_odd.tx_done) o_done++;
        end
        for (int b = 0; b < 10; b++) check($sformatf("t1_bit%0d_bad_cycles", b), bad[b], 0);
        check("t1_busy_bad_cycles", busy_bad, 0);
        check("t1_done_count", done_cnt, 1);
        check("t1_even_bad_cycles", e_bad, 0);
        check("t1_odd_bad_cycles", o_bad, 0);
        check("t1_even_done_count", e_done, 1);
        check("t1_odd_done_count", o_done, 1);

        // Test 2: tx_start held, 0x00 then 0xFF, two contiguous frames
        exp_a = {1'b1, 8'h00, 1'b0};
        exp_b = {1'b1, 8'hFF, 1'b0};
        clear_counts();
        @(negedge clk);
        if0.tx_data  = 8'h00;
        if0.tx_start = 1'b1;
        for (int c = 0; c <= 2 * FRAME + 1; c++) begin
            @(negedge clk);
            if (c == 100) if0.tx_data = 8'hFF;
            if (c < 2 * FRAME) begin
                if (c < FRAME) begin
                    if (if0.tx !== exp_a[c / CPB]) bad[c / CPB]++;
                end else begin
                    if (if0.tx !== exp_b[(c - FRAME) / CPB]) bad[10 + (c - FRAME) / CPB]++;
                end
                if (if0.tx_busy !== 1'b1) busy_bad++;
            end
            if (c == FRAME) begin
                if0.tx_start = 1'b0;
                check("t2_done1", if0.tx_done, 1'b1);
                check("t2_restart_tx_low", if0.tx, 1'b0);
            end
            if (c == 2 * FRAME) begin
                check("t2_done2", if0.tx_done, 1'b1);
                check("t2_busy_end", if0.tx_busy, 1'b0);
            end
            if (if0.tx_done) done_cnt++;
        end
        for (int b = 0; b < 20; b++) check($sformatf("t2_bit%0d_bad_cycles", b), bad[b], 0);
        check("t2_busy_bad_cycles", busy_bad, 0);
        check("t2_done_count", done_cnt, 2);

        // Test 3: 0xA3 frame, 0x55 request at cycle 1000 is ignored
        exp_a = {1'b1, 8'hA3, 1'b0};
        clear_counts();
        @(negedge clk);
        if0.tx_data  = 8'hA3;
        if0.tx_start = 1'b1;
        for (int c = 0; c <= FRAME + 500; c++) begin
            @(negedge clk);
            if (c == 0) if0.tx_start = 1'b0;
            if (c == 1000) begin
                if0.tx_data  = 8'h55;
                if0.tx_start = 1'b1;
            end
            if (c == 1001) if0.tx_start = 1'b0;
            if (c < FRAME) begin
                if (if0.tx !== exp_a[c / CPB]) bad[c / CPB]++;
            end else if (c > FRAME) begin
                if (if0.tx !== 1'b1 || if0.tx_busy !== 1'b0) busy_bad++;
            end
            if (c == FRAME) check("t3_done", if0.tx_done, 1'b1);
            if (if0.tx_done) done_cnt++;
        end
        for (int b = 0; b < 10; b++) check($sformatf("t3_bit%0d_bad_cycles", b), bad[b], 0);
        check("t3_idle_after_bad_cycles", busy_bad, 0);
        check("t3_done_count", done_cnt, 1);

        // Test 4: asynchronous reset mid-frame
        clear_counts();
        @(negedge clk);
        if0.tx_data  = 8'hA3;
        if0.tx_start = 1'b1;
        for (int c = 0; c <= 2000; c++) begin
            @(negedge clk);
            if (c == 0) if0.tx_start = 1'b0;
        end
        check("t4_busy_before", if0.tx_busy, 1'b1);
        #3 reset = 1'b1;
        #1;
        check("t4_tx_async", if0.tx, 1'b1);
        check("t4_busy_async", if0.tx_busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (if0.tx !== 1'b1 || if0.tx_busy !== 1'b0 || if0.tx_done !== 1'b0) busy_bad++;
        end
        check("t4_no_resume_bad_cycles", busy_bad, 0);

        // Test 5: ten random bytes streamed back-to-back, decoded mid-bit
        clear_counts();
        foreach (sent[i]) sent[i] = 8'($urandom);
        foreach (rx[i]) rx[i] = 8'h00;
        @(negedge clk);
        if0.tx_data  = sent[0];
        if0.tx_start = 1'b1;
        for (int c = 0; c <= 10 * FRAME + 1; c++) begin
            @(negedge clk);
            if (c % FRAME == 1 && c / FRAME < 9) if0.tx_data = sent[c / FRAME + 1];
            if (c == 9 * FRAME) if0.tx_start = 1'b0;
            if (c < 10 * FRAME && c % CPB == CPB / 2) begin
                if ((c % FRAME) / CPB == 0) begin
                    if (if0.tx !== 1'b0) bad[0]++;
                end else if ((c % FRAME) / CPB == 9) begin
                    if (if0.tx !== 1'b1) bad[1]++;
                end else begin
                    rx[c / FRAME][(c % FRAME) / CPB - 1] = if0.tx;
                end
            end
            if (if0.tx_done) begin
                done_cnt++;
                if (c == 0 || c % FRAME != 0) bad[2]++;
            end
            if (c == 10 * FRAME) check("t5_busy_end", if0.tx_busy, 1'b0);
        end
        for (int f = 0; f < 10; f++) check($sformatf("t5_byte%0d", f), rx[f], sent[f]);
        check("t5_start_bit_errors", bad[0], 0);
        check("t5_stop_bit_errors", bad[1], 0);
        check("t5_done_spacing_errors", bad[2], 0);
        check("t5_done_count", done_cnt, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
